// File: rtl/countdown_timer.sv
// Loadable down-counter with one-cycle terminal-count pulse and optional auto-reload.
// Input priority each cycle is load > stop > en.
module countdown_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             reload,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = (load_val != '0) ? StRun : StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StRun: begin
          if (stop) begin
            state_d = StIdle;
          end else if (en) begin
            if (count_q > WIDTH'(1)) begin
              count_d = count_q - WIDTH'(1);
            end else if (count_q == WIDTH'(1)) begin
              done_d = 1'b1;
              if (reload) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = StDone;
              end
            end else begin
              // Defensive: a zero count in RUN cannot arise from loads; never underflow.
              state_d = StIdle;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign count = count_q;
  assign busy  = (state_q == StRun);
  assign done  = done_q;
  assign zero  = (count_q == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer: an 8-bit instance for the main
// sequences and a 4-bit instance for the width edge.
module tb_countdown_timer;

  logic       clk;
  logic       rst;
  logic       load, en, reload, stop;
  logic [7:0] load_val;
  logic [7:0] count;
  logic       busy, done, zero;

  logic       load4, en4, reload4, stop4;
  logic [3:0] load_val4;
  logic [3:0] count4;
  logic       busy4, done4, zero4;

  int n_cmp;
  int n_err;
  int pulses;

  countdown_timer #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (load_val),
    .en       (en),
    .reload   (reload),
    .stop     (stop),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .zero     (zero)
  );

  countdown_timer #(.WIDTH(4)) dut4 (
    .clk      (clk),
    .rst      (rst),
    .load     (load4),
    .load_val (load_val4),
    .en       (en4),
    .reload   (reload4),
    .stop     (stop4),
    .count    (count4),
    .busy     (busy4),
    .done     (done4),
    .zero     (zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int ar_exp[9] = '{2, 1, 3, 2, 1, 3, 2, 1, 3};

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    load = 0; en = 0; reload = 0; stop = 0; load_val = '0;
    load4 = 0; en4 = 0; reload4 = 0; stop4 = 0; load_val4 = '0;
    #3;
    check("rst_count", 32'(count), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_zero", 32'(zero), 1);
    check("rst_count4", 32'(count4), 0);
    #2 rst = 1'b1;

    // Asynchronous reset while running at 0x37
    load = 1; load_val = 8'h37; en = 0;
    tick();
    check("pre_rst_count", 32'(count), 32'h37);
    check("pre_rst_busy", 32'(busy), 1);
    load = 0;
    #3 rst = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 0);
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_zero", 32'(zero), 1);
    rst = 1'b1;

    // One-shot from 5
    load = 1; load_val = 8'd5; reload = 0; en = 1;
    tick();
    check("os_load_count", 32'(count), 5);
    check("os_load_done", 32'(done), 0);
    check("os_load_busy", 32'(busy), 1);
    load = 0;
    for (int i = 4; i >= 1; i--) begin
      tick();
      check("os_count", 32'(count), 32'(i));
      check("os_done_low", 32'(done), 0);
      check("os_busy", 32'(busy), 1);
    end
    tick();
    check("os_tc_count", 32'(count), 0);
    check("os_tc_done", 32'(done), 1);
    check("os_tc_busy", 32'(busy), 0);
    check("os_tc_zero", 32'(zero), 1);
    tick();
    check("os_after_done", 32'(done), 0);
    check("os_after_count", 32'(count), 0);
    tick();
    check("os_idle_count", 32'(count), 0);
    check("os_idle_done", 32'(done), 0);
    check("os_idle_busy", 32'(busy), 0);

    // Auto-reload from 3
    load = 1; load_val = 8'd3; reload = 1; en = 1;
    tick();
    check("ar_load_count", 32'(count), 3);
    load = 0;
    pulses = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      check("ar_count", 32'(count), 32'(ar_exp[i]));
      check("ar_done", 32'(done), (ar_exp[i] == 3) ? 32'd1 : 32'd0);
      check("ar_busy", 32'(busy), 1);
      if (done) pulses++;
    end
    check("ar_pulses", 32'(pulses), 3);

    // Gating and stop
    load = 1; load_val = 8'd10; reload = 0; en = 0;
    tick();
    check("gt_load", 32'(count), 10);
    load = 0;
    en = 1; tick(); check("gt_en1", 32'(count), 9);
    en = 0; tick(); check("gt_en0", 32'(count), 9);
    en = 1; tick(); check("gt_en1b", 32'(count), 8);
    en = 0; tick(); check("gt_en0b", 32'(count), 8);
    stop = 1; en = 1;
    tick();
    check("stop_count", 32'(count), 8);
    check("stop_busy", 32'(busy), 0);
    check("stop_done", 32'(done), 0);
    stop = 0;
    tick();
    check("stop_idle_count", 32'(count), 8);
    check("stop_idle_busy", 32'(busy), 0);

    // Priority: load beats stop and terminal count
    load = 1; load_val = 8'd2; en = 1;
    tick();
    load = 0;
    tick();
    check("pr_at_one", 32'(count), 1);
    load = 1; load_val = 8'hFF; stop = 1; en = 1;
    tick();
    check("pr_count", 32'(count), 32'hFF);
    check("pr_busy", 32'(busy), 1);
    check("pr_done", 32'(done), 0);
    load = 1; load_val = 8'h00; stop = 0;
    tick();
    check("pr_zero_count", 32'(count), 0);
    check("pr_zero_busy", 32'(busy), 0);
    check("pr_zero_zero", 32'(zero), 1);
    check("pr_zero_done", 32'(done), 0);
    load = 0; en = 1;
    tick();
    check("pr_no_underflow", 32'(count), 0);
    check("pr_no_done", 32'(done), 0);
    en = 0;

    // 4-bit width edge from 0xF
    load4 = 1; load_val4 = 4'hF; reload4 = 0; en4 = 1;
    tick();
    check("w4_load", 32'(count4), 32'hF);
    load4 = 0;
    pulses = 0;
    for (int i = 14; i >= 0; i--) begin
      tick();
      check("w4_count", 32'(count4), 32'(i));
      check("w4_done", 32'(done4), (i == 0) ? 32'd1 : 32'd0);
      if (done4) pulses++;
    end
    check("w4_pulses", 32'(pulses), 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w4_no_wrap", 32'(count4), 0);
      check("w4_done_after", 32'(done4), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
